// File: rtl/conv2d_sched_pkg.sv
// ---------------------------------------------------------------------------
// conv2d_sched_pkg
// Shared definitions for the 3x3 convolution sequencer:
//   state_t    - sequencer FSM states (IDLE, FETCH, WAIT, RESULT)
//   KERNEL     - kernel edge length (3)
//   TAPS       - taps per window (9)
//   TAP_IDX_W  - width of a tap index (4 bits, covers 0..15)
// ---------------------------------------------------------------------------
package conv2d_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      WAIT   = 2'd2,
      RESULT = 2'd3
   } state_t;

   localparam int KERNEL    = 3;
   localparam int TAPS      = 9;
   localparam int TAP_IDX_W = 4;

endpackage

// File: rtl/conv2d_sched_if.sv
// ---------------------------------------------------------------------------
// conv2d_sched_if
// Result stream between the sequencer and its downstream consumer.
//   res_data   - signed window result
//   res_valid  - result is valid, held until accepted
//   res_ready  - consumer accepts the result
//   res_last   - qualifies the final window of the pass
// master: the sequencer (drives data/valid/last), slave: the consumer.
// ---------------------------------------------------------------------------
interface conv2d_sched_if #(
   parameter int ACC_WIDTH = 32
) ();

   logic signed [ACC_WIDTH-1:0] res_data;
   logic                        res_valid;
   logic                        res_ready;
   logic                        res_last;

   modport master (
      output res_data,
      output res_valid,
      output res_last,
      input  res_ready
   );

   modport slave (
      input  res_data,
      input  res_valid,
      input  res_last,
      output res_ready
   );

endinterface

// File: rtl/conv_win_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_win_addr_gen
// Window/tap position counters and read-address generation for a valid-mode
// 3x3 window walking an IMG_W x IMG_H map in raster order.
//   clk, rst_n     - clock, asynchronous active-low reset
//   i_clear        - return all counters to window (0,0), tap 0
//   i_stepTap      - advance to the next tap (wraps after tap 8)
//   i_stepWindow   - advance to the next window (col first, then row)
//   o_addr         - (row+ky)*IMG_W + col + kx for the current tap
//   o_tap          - current tap index ky*3+kx
//   o_lastTap      - current tap is tap 8
//   o_lastWindow   - current window is (OUT_H-1, OUT_W-1)
// ---------------------------------------------------------------------------
module conv_win_addr_gen
   import conv2d_sched_pkg::*;
#(
   parameter int IMG_W      = 8,
   parameter int IMG_H      = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_stepTap,
   input  logic                  i_stepWindow,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [TAP_IDX_W-1:0]  o_tap,
   output logic                  o_lastTap,
   output logic                  o_lastWindow
);

   localparam int OUT_W = IMG_W - 2;
   localparam int OUT_H = IMG_H - 2;

   logic [ADDR_WIDTH-1:0] r_row;
   logic [ADDR_WIDTH-1:0] r_col;
   logic [1:0]            r_kx;
   logic [1:0]            r_ky;
   logic [TAP_IDX_W-1:0]  r_tap;
   logic                  w_lastCol;
   logic                  w_lastRow;

   // Tap position inside the window. The kernel offsets kx/ky are kept as
   // their own small counters alongside the linear tap index so the address
   // never needs a divide or modulo by 3.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tap <= '0;
         r_kx  <= '0;
         r_ky  <= '0;
      end else if (i_clear) begin
         r_tap <= '0;
         r_kx  <= '0;
         r_ky  <= '0;
      end else if (i_stepTap) begin
         if (o_lastTap) begin
            r_tap <= '0;
            r_kx  <= '0;
            r_ky  <= '0;
         end else begin
            r_tap <= r_tap + TAP_IDX_W'(1);
            if (r_kx == 2'(KERNEL - 1)) begin
               r_kx <= '0;
               r_ky <= r_ky + 2'd1;
            end else begin
               r_kx <= r_kx + 2'd1;
            end
         end
      end
   end

   // Window position in raster order. Stepping past the final window wraps
   // back to (0,0) so the counters are already clean for the next pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_stepWindow) begin
         if (w_lastCol) begin
            r_col <= '0;
            r_row <= w_lastRow ? '0 : r_row + ADDR_WIDTH'(1);
         end else begin
            r_col <= r_col + ADDR_WIDTH'(1);
         end
      end
   end

   // Address of the current tap plus the end-of-window / end-of-pass flags
   // the FSM uses to decide where to go next.
   always_comb begin
      w_lastCol    = (r_col == ADDR_WIDTH'(OUT_W - 1));
      w_lastRow    = (r_row == ADDR_WIDTH'(OUT_H - 1));
      o_lastTap    = (r_tap == TAP_IDX_W'(TAPS - 1));
      o_lastWindow = w_lastCol && w_lastRow;
      o_tap        = r_tap;
      o_addr       = (r_row + ADDR_WIDTH'(r_ky)) * ADDR_WIDTH'(IMG_W)
                     + r_col + ADDR_WIDTH'(r_kx);
   end

endmodule

// File: rtl/conv2d_sched.sv
// ---------------------------------------------------------------------------
// conv2d_sched
// Sequencer feeding a 3x3 signed MAC. Walks every valid-mode window of the
// map, streams 9 pixel/weight pairs per window, captures the MAC result and
// offers it on a valid/ready stream.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start/busy/done     - pass control and status
//   w_we/w_idx/w_data   - weight file write port (idle only)
//   mem_rd_en/mem_addr  - synchronous-read memory request
//   mem_rd_data         - memory data, one cycle after the request
//   mac_clr             - clears the MAC and aligns its tap counter
//   mac_pixel           - pass-through of mem_rd_data
//   mac_weight          - weight aligned with mac_pixel
//   mac_valid           - tap valid towards the MAC
//   mac_acc/_valid      - accumulated window result from the MAC
//   resIf               - result stream (res_data/valid/ready/last)
// ---------------------------------------------------------------------------
module conv2d_sched
   import conv2d_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int IMG_W      = 8,
   parameter int IMG_H      = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   input  logic                         w_we,
   input  logic [TAP_IDX_W-1:0]         w_idx,
   input  logic signed [DATA_WIDTH-1:0] w_data,
   output logic                         mem_rd_en,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   input  logic signed [DATA_WIDTH-1:0] mem_rd_data,
   output logic                         mac_clr,
   output logic signed [DATA_WIDTH-1:0] mac_pixel,
   output logic signed [DATA_WIDTH-1:0] mac_weight,
   output logic                         mac_valid,
   input  logic signed [ACC_WIDTH-1:0]  mac_acc,
   input  logic                         mac_acc_valid,
   conv2d_sched_if.master               resIf
);

   state_t                        r_state;
   state_t                        w_nextState;
   logic signed [DATA_WIDTH-1:0]  r_weight [TAPS];
   logic                          r_macClr;
   logic                          r_busy;
   logic                          r_done;
   logic                          r_macValid;
   logic signed [DATA_WIDTH-1:0]  r_macWeight;
   logic signed [ACC_WIDTH-1:0]   r_resData;
   logic                          r_resValid;
   logic                          w_clear;
   logic                          w_stepTap;
   logic                          w_stepWindow;
   logic                          w_finish;
   logic                          w_handshake;
   logic                          w_rdEn;
   logic                          w_lastTap;
   logic                          w_lastWindow;
   logic [TAP_IDX_W-1:0]          w_tap;

   conv_win_addr_gen #(
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addrGen (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (w_clear),
      .i_stepTap    (w_stepTap),
      .i_stepWindow (w_stepWindow),
      .o_addr       (mem_addr),
      .o_tap        (w_tap),
      .o_lastTap    (w_lastTap),
      .o_lastWindow (w_lastWindow)
   );

   // State register. Reset lands in IDLE from any state, which also abandons
   // a pass in flight without producing a result or done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and counter strobes. FETCH issues one read per cycle, WAIT
   // sits until the MAC reports the window sum, and RESULT stalls the whole
   // pipeline until the consumer takes the result.
   always_comb begin
      w_nextState  = r_state;
      w_clear      = 1'b0;
      w_stepTap    = 1'b0;
      w_stepWindow = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_clear     = 1'b1;
               w_nextState = FETCH;
            end
         end
         FETCH: begin
            w_stepTap = 1'b1;
            if (w_lastTap) begin
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            if (mac_acc_valid) begin
               w_nextState = RESULT;
            end
         end
         RESULT: begin
            if (w_handshake) begin
               w_stepWindow = 1'b1;
               if (w_lastWindow) begin
                  w_finish    = 1'b1;
                  w_nextState = IDLE;
               end else begin
                  w_nextState = FETCH;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Weight file. Writes are only taken in IDLE so the kernel cannot change
   // under a running pass; indices past tap 8 are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) begin
            r_weight[k] <= '0;
         end
      end else if ((r_state == IDLE) && w_we && (w_idx <= TAP_IDX_W'(TAPS - 1))) begin
         r_weight[w_idx] <= w_data;
      end
   end

   // Pass control: mac_clr is a one-cycle echo of the accepted start, busy
   // covers the whole pass, and done pulses alongside busy falling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_macClr <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_macClr <= w_clear;
         r_done   <= w_finish;
         if (w_clear) begin
            r_busy <= 1'b1;
         end else if (w_finish) begin
            r_busy <= 1'b0;
         end
      end
   end

   // MAC feed. The memory returns data one cycle after the request, so the
   // valid and weight are delayed by one register to line up with the pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_macValid  <= 1'b0;
         r_macWeight <= '0;
      end else begin
         r_macValid <= w_rdEn;
         if (r_state == FETCH) begin
            r_macWeight <= r_weight[w_tap];
         end
      end
   end

   // Result holding register. The MAC sum is only captured in WAIT and is
   // frozen until the consumer handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resData  <= '0;
         r_resValid <= 1'b0;
      end else if ((r_state == WAIT) && mac_acc_valid) begin
         r_resData  <= mac_acc;
         r_resValid <= 1'b1;
      end else if ((r_state == RESULT) && w_handshake) begin
         r_resValid <= 1'b0;
      end
   end

   // Output wiring.
   always_comb begin
      w_rdEn      = (r_state == FETCH);
      w_handshake = r_resValid && resIf.res_ready;
   end

   assign mem_rd_en       = w_rdEn;
   assign mac_clr         = r_macClr;
   assign mac_pixel       = mem_rd_data;
   assign mac_weight      = r_macWeight;
   assign mac_valid       = r_macValid;
   assign busy            = r_busy;
   assign done            = r_done;
   assign resIf.res_data  = r_resData;
   assign resIf.res_valid = r_resValid;
   assign resIf.res_last  = r_resValid && w_lastWindow;

endmodule

// File: tb/tb_conv2d_sched.sv
// ---------------------------------------------------------------------------
// tb_conv2d_sched
// Bench for conv2d_sched on a 4x4 map with a behavioural synchronous-read
// memory and a behavioural 9-tap MAC. Expected results are hand-computed and
// queued when a pass is launched; a monitor pops them on each handshake.
// ---------------------------------------------------------------------------
module tb_conv2d_sched;
   import conv2d_sched_pkg::*;

   localparam int DW    = 8;
   localparam int AW    = 32;
   localparam int IMGW  = 4;
   localparam int IMGH  = 4;
   localparam int ADDRW = 6;

   typedef struct {
      int data;
      bit last;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 w_we = 1'b0;
   logic [3:0]           w_idx = '0;
   logic signed [DW-1:0] w_data = '0;
   logic                 busy;
   logic                 done;
   logic                 mem_rd_en;
   logic [ADDRW-1:0]     mem_addr;
   logic signed [DW-1:0] mem_rd_data = '0;
   logic                 mac_clr;
   logic signed [DW-1:0] mac_pixel;
   logic signed [DW-1:0] mac_weight;
   logic                 mac_valid;
   logic signed [AW-1:0] mac_acc = '0;
   logic                 mac_acc_valid = 1'b0;

   logic signed [DW-1:0] mem [0:63];
   int                   macCnt = 0;
   int                   macSum = 0;
   int                   cycle = 0;
   int                   doneCount = 0;
   int                   nChecks = 0;
   int                   nFails = 0;
   exp_t                 expQ[$];
   int                   addrLog[$];
   int                   expAddr[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

   conv2d_sched_if #(.ACC_WIDTH(AW)) resIf ();

   conv2d_sched #(
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW),
      .IMG_W      (IMGW),
      .IMG_H      (IMGH),
      .ADDR_WIDTH (ADDRW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .w_we          (w_we),
      .w_idx         (w_idx),
      .w_data        (w_data),
      .mem_rd_en     (mem_rd_en),
      .mem_addr      (mem_addr),
      .mem_rd_data   (mem_rd_data),
      .mac_clr       (mac_clr),
      .mac_pixel     (mac_pixel),
      .mac_weight    (mac_weight),
      .mac_valid     (mac_valid),
      .mac_acc       (mac_acc),
      .mac_acc_valid (mac_acc_valid),
      .resIf         (resIf.master)
   );

   // Free-running clock and cycle counter used for latency measurements.
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Synchronous-read feature map memory.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   // Behavioural MAC: accumulates 9 taps, presents the sum for one cycle.
   always @(posedge clk) begin
      if (mac_clr) begin
         macCnt        <= 0;
         macSum        <= 0;
         mac_acc_valid <= 1'b0;
         mac_acc       <= '0;
      end else begin
         mac_acc_valid <= 1'b0;
         if (mac_valid) begin
            if (macCnt == 8) begin
               mac_acc       <= macSum + int'(mac_pixel) * int'(mac_weight);
               mac_acc_valid <= 1'b1;
               macSum        <= 0;
               macCnt        <= 0;
            end else begin
               macSum <= macSum + int'(mac_pixel) * int'(mac_weight);
               macCnt <= macCnt + 1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Scoreboard monitor, plus done and read-address logging.
   always @(negedge clk) begin
      exp_t e;
      if (done) doneCount++;
      if (mem_rd_en) addrLog.push_back(int'(mem_addr));
      if (rst_n && resIf.res_valid && resIf.res_ready) begin
         if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected_result: actual=%0d expected=none", resIf.res_data);
         end else begin
            e = expQ.pop_front();
            checkOutput("res_data", resIf.res_data, e.data);
            checkOutput("res_last", resIf.res_last, e.last);
         end
      end
   end

   task automatic pushExp(input int v0, input int v1, input int v2, input int v3);
      exp_t e;
      e.last = 1'b0;
      e.data = v0; expQ.push_back(e);
      e.data = v1; expQ.push_back(e);
      e.data = v2; expQ.push_back(e);
      e.data = v3; e.last = 1'b1; expQ.push_back(e);
   endtask

   task automatic fillMem(input bit allNeg);
      for (int i = 0; i < 64; i++) mem[i] = allNeg ? -8'sd128 : 8'(i);
   endtask

   task automatic setWeight(input int idx, input int val);
      @(posedge clk); #1;
      w_we = 1'b1; w_idx = 4'(idx); w_data = 8'(val);
      @(posedge clk); #1;
      w_we = 1'b0;
   endtask

   task automatic loadAll(input int val);
      @(posedge clk); #1;
      for (int k = 0; k < 9; k++) begin
         w_we = 1'b1; w_idx = 4'(k); w_data = 8'(val);
         @(posedge clk); #1;
      end
      w_we = 1'b0;
   endtask

   // Pulse start and check the first cycle of the pass; returns the cycle
   // stamp of FETCH cycle 0.
   task automatic applyStimulus(output int tFetch);
      doneCount = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      checkOutput("mac_clr_on", mac_clr, 1);
      checkOutput("busy_on", busy, 1);
      checkOutput("fetch_started", mem_rd_en, 1);
      tFetch = cycle;
      @(negedge clk);
      checkOutput("mac_clr_off", mac_clr, 0);
   endtask

   task automatic waitDone(input int budget, output int tDone);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL done_timeout: no done within %0d cycles", budget);
      end
      tDone = cycle;
   endtask

   task automatic finishPass(input bit checkTiming, input int tFetch);
      int tDone;
      waitDone(400, tDone);
      if (checkTiming) checkOutput("pass_cycles", tDone - tFetch, 48);
      checkOutput("busy_with_done", busy, 0);
      repeat (3) @(negedge clk);
      checkOutput("done_pulses", doneCount, 1);
      checkOutput("results_left", expQ.size(), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int tF;
      int n;
      resIf.res_ready = 1'b1;
      fillMem(1'b0);

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_rd_en", mem_rd_en, 0);
      checkOutput("rst_addr", mem_addr, 0);
      checkOutput("rst_mac_clr", mac_clr, 0);
      checkOutput("rst_mac_valid", mac_valid, 0);
      checkOutput("rst_mac_weight", mac_weight, 0);
      checkOutput("rst_res_valid", resIf.res_valid, 0);
      checkOutput("rst_res_data", resIf.res_data, 0);
      checkOutput("rst_res_last", resIf.res_last, 0);
      rst_n = 1'b1;

      $display("[TB] scenario 1: all-ones kernel");
      loadAll(1);
      pushExp(45, 54, 81, 90);
      applyStimulus(tF);
      finishPass(1'b1, tF);

      $display("[TB] scenario 2: centre tap only, address walk");
      loadAll(0);
      setWeight(4, 1);
      addrLog.delete();
      pushExp(5, 6, 9, 10);
      applyStimulus(tF);
      finishPass(1'b1, tF);
      checkOutput("addr_count", addrLog.size(), 36);
      if (addrLog.size() == 36) begin
         for (int k = 0; k < 9; k++)
            checkOutput($sformatf("addr_w3_t%0d", k), addrLog[27 + k], expAddr[k]);
      end

      $display("[TB] scenario 3: -128 x -128");
      fillMem(1'b1);
      loadAll(-128);
      pushExp(147456, 147456, 147456, 147456);
      applyStimulus(tF);
      finishPass(1'b1, tF);

      $display("[TB] scenario 4: backpressure on window 0");
      fillMem(1'b0);
      loadAll(1);
      pushExp(45, 54, 81, 90);
      @(posedge clk); #1 resIf.res_ready = 1'b0;
      applyStimulus(tF);
      n = 0;
      while (!resIf.res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("stall_res_valid_seen", resIf.res_valid, 1);
      for (int i = 0; i < 20; i++) begin
         checkOutput("stall_res_data", resIf.res_data, 45);
         checkOutput("stall_res_valid", resIf.res_valid, 1);
         checkOutput("stall_rd_en", mem_rd_en, 0);
         @(negedge clk);
      end
      @(posedge clk); #1 resIf.res_ready = 1'b1;
      finishPass(1'b0, tF);

      $display("[TB] scenario 5: start and w_we during busy");
      pushExp(45, 54, 81, 90);
      applyStimulus(tF);
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1; w_we = 1'b1; w_idx = 4'd0; w_data = 8'sd7;
      @(posedge clk); #1;
      start = 1'b0; w_we = 1'b0;
      finishPass(1'b1, tF);

      $display("[TB] scenario 6: reset during window 1");
      begin
         exp_t e;
         e.data = 45; e.last = 1'b0;
         expQ.push_back(e);
      end
      applyStimulus(tF);
      repeat (13) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_rd_en", mem_rd_en, 0);
      checkOutput("midrst_addr", mem_addr, 0);
      checkOutput("midrst_mac_valid", mac_valid, 0);
      checkOutput("midrst_mac_weight", mac_weight, 0);
      checkOutput("midrst_mac_clr", mac_clr, 0);
      checkOutput("midrst_res_valid", resIf.res_valid, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_results_left", expQ.size(), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("no_done_after_reset", doneCount, 0);

      pushExp(0, 0, 0, 0);
      applyStimulus(tF);
      finishPass(1'b1, tF);

      loadAll(1);
      pushExp(45, 54, 81, 90);
      applyStimulus(tF);
      finishPass(1'b1, tF);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
